// File: rtl/traceback_ctrl.sv
// -----------------------------------------------------------------------------
// traceback_ctrl
// Survivor-memory traceback controller for a Viterbi decoder.
//
// Each survivor column from the ACS stage is written into a circular
// survivor memory. Once TB_DEPTH columns are held, every accepted column
// starts a full traceback. The traceback walks TB_DEPTH columns backwards,
// starting from the newest column and the best-metric state. It then reports
// the state reached at the oldest column.
//
// Optional feature: define TRACEBACK_CTRL_CNT_EN to add o_tb_cnt, a 16-bit
// saturating count of completed tracebacks.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   en_m         global enable; 0 freezes every register
//   i_stg_vld    ACS stage offers a survivor column
//   o_stg_rdy    controller accepts a column this cycle (FILL only)
//   i_best_st    best-metric state accompanying the offered column
//   o_wr_en      survivor column write strobe
//   o_wr_addr    column address to write
//   o_rd_addr    column address to read during traceback
//   o_rd_st      state row to read within o_rd_addr
//   i_rd_prv_st  previous state returned by memory one cycle after a read
//   o_dec_st     decided state at the oldest column
//   o_dec_vld    one-cycle pulse qualifying o_dec_st
//   o_tb_cnt     (TRACEBACK_CTRL_CNT_EN only) completed traceback count
// -----------------------------------------------------------------------------
module traceback_ctrl #(
   parameter int TB_DEPTH = 16,
   parameter int ADDR_W   = 4,
   parameter int ST_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_m,
   input  logic              i_stg_vld,
   output logic              o_stg_rdy,
   input  logic [ST_W-1:0]   i_best_st,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [ST_W-1:0]   o_rd_st,
   input  logic [ST_W-1:0]   i_rd_prv_st,
   output logic [ST_W-1:0]   o_dec_st,
   output logic              o_dec_vld
`ifdef TRACEBACK_CTRL_CNT_EN
   ,
   output logic [15:0]       o_tb_cnt
`endif
);

   // Counters need one extra bit so they can hold TB_DEPTH itself.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(TB_DEPTH);
   localparam logic [CNT_W-1:0] LAST_STEP_C = CNT_W'(TB_DEPTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FILL     = 3'd1,
      ST_TB_ISSUE = 3'd2,
      ST_TB_WAIT  = 3'd3,
      ST_EMIT     = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0]  fill_cnt_r;
   logic [CNT_W-1:0]  fill_next_s;
   logic [CNT_W-1:0]  step_cnt_r;
   logic [ST_W-1:0]   tb_st_r;
   logic [ST_W-1:0]   dec_st_r;
   logic              dec_vld_r;
   logic              accept_s;

   assign accept_s = en_m & i_stg_vld & (state_r == ST_FILL);

   // Saturating fill count after a possible accept this cycle.
   always_comb begin
      fill_next_s = fill_cnt_r;
      if (fill_cnt_r == DEPTH_C) begin
         fill_next_s = fill_cnt_r;
      end else begin
         fill_next_s = fill_cnt_r + CNT_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else if (en_m) begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; a disabled cycle keeps the current state.
   always_comb begin
      state_s = state_r;
      if (en_m) begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_FILL;
            end
            ST_FILL: begin
               if (accept_s && (fill_next_s == DEPTH_C)) begin
                  state_s = ST_TB_ISSUE;
               end else begin
                  state_s = ST_FILL;
               end
            end
            ST_TB_ISSUE: begin
               state_s = ST_TB_WAIT;
            end
            ST_TB_WAIT: begin
               if (step_cnt_r == LAST_STEP_C) begin
                  state_s = ST_EMIT;
               end else begin
                  state_s = ST_TB_ISSUE;
               end
            end
            ST_EMIT: begin
               state_s = ST_FILL;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Pointers, counters and traceback state; all frozen while en_m is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {ADDR_W{1'b0}};
         rd_ptr_r   <= {ADDR_W{1'b0}};
         fill_cnt_r <= {CNT_W{1'b0}};
         step_cnt_r <= {CNT_W{1'b0}};
         tb_st_r    <= {ST_W{1'b0}};
      end else if (en_m) begin
         case (state_r)
            ST_FILL: begin
               if (accept_s) begin
                  wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
                  fill_cnt_r <= fill_next_s;
                  tb_st_r    <= i_best_st;
                  // Traceback starts at the column written this cycle.
                  if (fill_next_s == DEPTH_C) begin
                     rd_ptr_r   <= wr_ptr_r;
                     step_cnt_r <= {CNT_W{1'b0}};
                  end
               end
            end
            ST_TB_WAIT: begin
               tb_st_r    <= i_rd_prv_st;
               rd_ptr_r   <= rd_ptr_r - ADDR_W'(1);
               step_cnt_r <= step_cnt_r + CNT_W'(1);
            end
            ST_EMIT: begin
               // One column of history slides out; the next accept refills it.
               fill_cnt_r <= LAST_STEP_C;
            end
            default: begin
               fill_cnt_r <= fill_cnt_r;
            end
         endcase
      end
   end

   // Registered decision output: the pulse appears the cycle after EMIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_vld_r <= 1'b0;
         dec_st_r  <= {ST_W{1'b0}};
      end else if (en_m) begin
         dec_vld_r <= (state_r == ST_EMIT);
         if (state_r == ST_EMIT) begin
            dec_st_r <= tb_st_r;
         end
      end
   end

`ifdef TRACEBACK_CTRL_CNT_EN
   logic [15:0] tb_cnt_r;

   // Saturating count of completed tracebacks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tb_cnt_r <= 16'h0000;
      end else if (en_m && (state_r == ST_EMIT) && (tb_cnt_r != 16'hFFFF)) begin
         tb_cnt_r <= tb_cnt_r + 16'h0001;
      end
   end

   assign o_tb_cnt = tb_cnt_r;
`endif

   assign o_stg_rdy = (state_r == ST_FILL);
   assign o_wr_en   = accept_s;
   assign o_wr_addr = wr_ptr_r;
   // Read address/state track the traceback registers, so they hold when frozen.
   assign o_rd_addr = rd_ptr_r;
   assign o_rd_st   = tb_st_r;
   assign o_dec_st  = dec_st_r;
   assign o_dec_vld = dec_vld_r & en_m;

endmodule
